// File: rtl/prog_mem_port_arbiter_pkg.sv
// Shared constants and encodings for the program-memory port arbiter.
// Word and memory sizes mirror the system-wide command width and program memory depth.
package prog_mem_port_arbiter_pkg;

  localparam int COMMAND_WIDTH    = 32;
  localparam int PROGRAM_MEM_SIZE = 1024;

  typedef enum logic [1:0] {
    ST_RUN     = 2'h0,
    ST_DRAIN   = 2'h1,
    ST_FLASH   = 2'h2,
    ST_RECOVER = 2'h3
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/prog_mem_port_arbiter_if.sv
// Bundle of every requester, memory and status signal around the program-memory port.
// Read handshake: a requester raises req with a stable addr and holds both until gnt is seen high in the
// same cycle; the address is taken in that cycle and rvalid/rdata follow exactly one cycle later.
interface prog_mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  import prog_mem_port_arbiter_pkg::*;

  logic                  flash_active_in;
  logic                  flash_we_in;
  logic [ADDR_WIDTH-1:0] flash_addr_in;
  logic [DATA_WIDTH-1:0] flash_data_in;

  logic                  cpu_req_in;
  logic [ADDR_WIDTH-1:0] cpu_addr_in;
  logic                  cpu_gnt_out;
  logic                  cpu_rvalid_out;
  logic [DATA_WIDTH-1:0] cpu_rdata_out;

  logic                  dbg_req_in;
  logic [ADDR_WIDTH-1:0] dbg_addr_in;
  logic                  dbg_gnt_out;
  logic                  dbg_rvalid_out;
  logic [DATA_WIDTH-1:0] dbg_rdata_out;

  logic                  mem_en_out;
  logic                  mem_we_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_wdata_out;
  logic [DATA_WIDTH-1:0] mem_rdata_in;

  logic                  cpu_stall_out;
  logic [ADDR_WIDTH:0]   write_count_out;
  logic                  flash_err_out;
  arb_state_e            state_out;

  modport slave (
    input  flash_active_in, flash_we_in, flash_addr_in, flash_data_in,
    input  cpu_req_in, cpu_addr_in, dbg_req_in, dbg_addr_in, mem_rdata_in,
    output cpu_gnt_out, cpu_rvalid_out, cpu_rdata_out,
    output dbg_gnt_out, dbg_rvalid_out, dbg_rdata_out,
    output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output cpu_stall_out, write_count_out, flash_err_out, state_out
  );

  modport master (
    output flash_active_in, flash_we_in, flash_addr_in, flash_data_in,
    output cpu_req_in, cpu_addr_in, dbg_req_in, dbg_addr_in, mem_rdata_in,
    input  cpu_gnt_out, cpu_rvalid_out, cpu_rdata_out,
    input  dbg_gnt_out, dbg_rvalid_out, dbg_rdata_out,
    input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  cpu_stall_out, write_count_out, flash_err_out, state_out
  );

endinterface

// File: rtl/prog_mem_port_arbiter_read_picker.sv
// Two-requester read arbiter: CPU by default, debug forced through after STARVE_LIMIT
// CPU wins while it waits. Also tracks which requester owns the word returning next cycle.
module prog_mem_read_picker
  import prog_mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic starve_clr_i,
  input  logic cpu_req_i,
  input  logic dbg_req_i,
  output logic cpu_gnt_o,
  output logic dbg_gnt_o,
  output logic cpu_rvalid_o,
  output logic dbg_rvalid_o
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [CW-1:0] starve_q, starve_d;
  logic          rvalid_q;
  owner_e        owner_q, owner_d;
  logic          dbg_win;

  always_comb begin
    dbg_win   = dbg_req_i && (!cpu_req_i || (starve_q == CW'(STARVE_LIMIT)));
    dbg_gnt_o = en_i && dbg_win;
    cpu_gnt_o = en_i && cpu_req_i && !dbg_win;

    starve_d = starve_q;
    if (starve_clr_i || dbg_gnt_o) begin
      starve_d = '0;
    end else if (cpu_gnt_o && dbg_req_i) begin
      starve_d = starve_q + 1'b1;
    end

    owner_d = owner_q;
    if (dbg_gnt_o) begin
      owner_d = OWNER_DBG;
    end else if (cpu_gnt_o) begin
      owner_d = OWNER_CPU;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      rvalid_q <= 1'b0;
      owner_q  <= OWNER_CPU;
    end else begin
      starve_q <= starve_d;
      rvalid_q <= cpu_gnt_o || dbg_gnt_o;
      owner_q  <= owner_d;
    end
  end

  assign cpu_rvalid_o = rvalid_q && (owner_q == OWNER_CPU);
  assign dbg_rvalid_o = rvalid_q && (owner_q == OWNER_DBG);

endmodule

// File: rtl/prog_mem_port_arbiter.sv
// Owns the single program-memory port: CPU/debug reads in RUN, exclusive programmer writes in FLASH,
// with a one-cycle drain before the session and a two-cycle recovery after it.
module prog_mem_port_arbiter
  import prog_mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = $clog2(PROGRAM_MEM_SIZE),
  parameter int DATA_WIDTH   = COMMAND_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input logic                    CLK_100MHz_in,
  input logic                    rst_n_in,
  prog_mem_port_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  arb_state_e          state_q;
  logic                rec_cnt_q;
  logic [ADDR_WIDTH:0] write_count_q;
  logic                flash_err_q;

  logic arb_en;
  logic starve_clr;
  logic cpu_gnt, dbg_gnt;
  logic cpu_rvalid, dbg_rvalid;

  // Gating with rst_n_in keeps the combinational grants and port quiet while reset is held.
  assign arb_en     = rst_n_in && (state_q == ST_RUN) && !bus.flash_active_in;
  assign starve_clr = (state_q == ST_RECOVER) && rec_cnt_q;

  prog_mem_read_picker #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_picker (
    .clk_i        (CLK_100MHz_in),
    .rst_ni       (rst_n_in),
    .en_i         (arb_en),
    .starve_clr_i (starve_clr),
    .cpu_req_i    (bus.cpu_req_in),
    .dbg_req_i    (bus.dbg_req_in),
    .cpu_gnt_o    (cpu_gnt),
    .dbg_gnt_o    (dbg_gnt),
    .cpu_rvalid_o (cpu_rvalid),
    .dbg_rvalid_o (dbg_rvalid)
  );

  always_ff @(posedge CLK_100MHz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_RUN;
      rec_cnt_q     <= 1'b0;
      write_count_q <= '0;
      flash_err_q   <= 1'b0;
    end else begin
      if (bus.flash_we_in && (state_q != ST_FLASH)) begin
        flash_err_q <= 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (bus.flash_active_in) begin
            state_q       <= ST_DRAIN;
            write_count_q <= '0;
          end
        end
        ST_DRAIN: begin
          rec_cnt_q <= 1'b0;
          state_q   <= bus.flash_active_in ? ST_FLASH : ST_RECOVER;
        end
        ST_FLASH: begin
          if (bus.flash_we_in && (write_count_q != WC_MAX)) begin
            write_count_q <= write_count_q + 1'b1;
          end
          if (!bus.flash_active_in) begin
            rec_cnt_q <= 1'b0;
            state_q   <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt_q) begin
            state_q <= ST_RUN;
          end else begin
            rec_cnt_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    bus.mem_en_out    = 1'b0;
    bus.mem_we_out    = 1'b0;
    bus.mem_addr_out  = '0;
    bus.mem_wdata_out = '0;
    if (rst_n_in) begin
      if (state_q == ST_FLASH) begin
        bus.mem_en_out    = bus.flash_we_in;
        bus.mem_we_out    = bus.flash_we_in;
        bus.mem_addr_out  = bus.flash_addr_in;
        bus.mem_wdata_out = bus.flash_data_in;
      end else if (cpu_gnt) begin
        bus.mem_en_out   = 1'b1;
        bus.mem_addr_out = bus.cpu_addr_in;
      end else if (dbg_gnt) begin
        bus.mem_en_out   = 1'b1;
        bus.mem_addr_out = bus.dbg_addr_in;
      end
    end
  end

  assign bus.cpu_gnt_out    = cpu_gnt;
  assign bus.dbg_gnt_out    = dbg_gnt;
  assign bus.cpu_rvalid_out = cpu_rvalid;
  assign bus.dbg_rvalid_out = dbg_rvalid;
  assign bus.cpu_rdata_out  = cpu_rvalid ? bus.mem_rdata_in : '0;
  assign bus.dbg_rdata_out  = dbg_rvalid ? bus.mem_rdata_in : '0;

  // A pending flash session stalls the CPU from the cycle it is requested, before DRAIN is entered.
  assign bus.cpu_stall_out = rst_n_in &&
                             ((state_q != ST_RUN) || bus.flash_active_in ||
                              (bus.cpu_req_in && !cpu_gnt));

  assign bus.write_count_out = write_count_q;
  assign bus.flash_err_out   = flash_err_q;
  assign bus.state_out       = state_q;

endmodule
